// File: rtl/dp_hpd_pkg.sv
// Shared types and constants for the HPD sink-connection controller.
package dp_hpd_pkg;

  typedef enum logic [2:0] {
    StDisc,
    StSettle,
    StTrain,
    StUp,
    StFailed
  } hpd_ctrl_state_e;

  typedef enum logic [1:0] {
    EvtPlug   = 2'd0,
    EvtUnplug = 2'd1,
    EvtIrq    = 2'd2,
    EvtLtFail = 2'd3
  } hpd_evt_e;

  localparam int unsigned CLK_FREQ = 100_000;
  localparam int unsigned MS_TICKS = CLK_FREQ / 1000;

endpackage

// File: rtl/hpd_evt_fifo.sv
// Small valid/ready event FIFO with a sticky overflow flag for dropped pushes.
module hpd_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, count;
  logic             full, pop, wr, drop;

  // Wrap bit makes wptr - rptr the exact occupancy, 0..DEPTH.
  assign count = wptr - rptr;
  assign full  = (count == FullCount);
  assign valid = (count != '0);
  assign pop   = valid & ready;
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;
  assign data  = valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hpd_link_ctrl.sv
// Sink-connection controller: settles HPD, launches link training with bounded retries,
// and reports plug/unplug/IRQ/training-failure events through a small queue.
module hpd_link_ctrl
  import dp_hpd_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 200,
  parameter int unsigned LT_RETRY_MAX  = 3,
  parameter int unsigned EVT_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hpd_detect,
  input  logic       hpd_irq,
  output logic       lt_start,
  input  logic       lt_done,
  input  logic       lt_fail,
  output logic       link_up,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic       evt_overflow,
  input  logic       ovf_clr
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      RetryMax   = 4'(LT_RETRY_MAX);

  hpd_ctrl_state_e state;
  logic [CntW-1:0] settle_cnt;
  logic [3:0]      attempt;
  logic            det_q, irq_q;
  logic            det_rise, det_fall, irq_rise, settle_done, retry_left;
  logic            push;
  hpd_evt_e        push_evt;

  assign det_rise    = hpd_detect & ~det_q;
  assign det_fall    = ~hpd_detect & det_q;
  assign irq_rise    = hpd_irq & ~irq_q;
  assign settle_done = (settle_cnt == SettleLast);
  assign retry_left  = (attempt < RetryMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      det_q <= hpd_detect;
      irq_q <= hpd_irq;
    end
  end

  // Unplug takes priority so a coincident IRQ or training result never gets queued.
  always_comb begin
    push     = 1'b0;
    push_evt = EvtPlug;
    unique case (state)
      StDisc: ;
      StSettle: begin
        if (hpd_detect && settle_done) begin
          push     = 1'b1;
          push_evt = EvtPlug;
        end
      end
      StTrain: begin
        if (det_fall) begin
          push     = 1'b1;
          push_evt = EvtUnplug;
        end else if (lt_fail && !retry_left) begin
          push     = 1'b1;
          push_evt = EvtLtFail;
        end
      end
      StUp: begin
        if (det_fall) begin
          push     = 1'b1;
          push_evt = EvtUnplug;
        end else if (irq_rise) begin
          push     = 1'b1;
          push_evt = EvtIrq;
        end
      end
      StFailed: begin
        if (det_fall) begin
          push     = 1'b1;
          push_evt = EvtUnplug;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StDisc;
      settle_cnt <= '0;
      attempt    <= '0;
      lt_start   <= 1'b0;
      link_up    <= 1'b0;
    end else begin
      lt_start <= 1'b0;
      unique case (state)
        StDisc: begin
          if (det_rise) begin
            state      <= StSettle;
            settle_cnt <= '0;
          end
        end
        StSettle: begin
          if (!hpd_detect) begin
            state <= StDisc;
          end else if (settle_done) begin
            state    <= StTrain;
            lt_start <= 1'b1;
            attempt  <= 4'd1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        StTrain: begin
          if (det_fall) begin
            state   <= StDisc;
            attempt <= '0;
          end else if (lt_fail) begin
            if (retry_left) begin
              lt_start <= 1'b1;
              attempt  <= attempt + 1'b1;
            end else begin
              state <= StFailed;
            end
          end else if (lt_done) begin
            state   <= StUp;
            link_up <= 1'b1;
          end
        end
        StUp, StFailed: begin
          if (det_fall) begin
            state   <= StDisc;
            attempt <= '0;
            link_up <= 1'b0;
          end
        end
        default: begin
          state   <= StDisc;
          link_up <= 1'b0;
        end
      endcase
    end
  end

  hpd_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (2)
  ) u_evt_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_evt),
    .valid     (evt_valid),
    .ready     (evt_ready),
    .data      (evt_code),
    .overflow  (evt_overflow),
    .ovf_clr   (ovf_clr)
  );

endmodule

// File: tb/tb_hpd_link_ctrl.sv
// Directed self-checking bench for hpd_link_ctrl with default parameters.
module tb_hpd_link_ctrl;
  import dp_hpd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hpd_detect = 1'b0;
  logic       hpd_irq = 1'b0;
  logic       lt_done = 1'b0;
  logic       lt_fail = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       lt_start, link_up, evt_valid, evt_overflow;
  logic [1:0] evt_code;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_lt_start = 0;
  logic [1:0] popped[$];

  always #5 clk = ~clk;

  hpd_link_ctrl #(
    .SETTLE_CYCLES (200),
    .LT_RETRY_MAX  (3),
    .EVT_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hpd_detect   (hpd_detect),
    .hpd_irq      (hpd_irq),
    .lt_start     (lt_start),
    .lt_done      (lt_done),
    .lt_fail      (lt_fail),
    .link_up      (link_up),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr)
  );

  // Log every lt_start pulse and every accepted event.
  always @(posedge clk) begin
    if (lt_start) n_lt_start <= n_lt_start + 1;
    if (rst_n && evt_valid && evt_ready) popped.push_back(evt_code);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Compare popped events from index base against n packed 2-bit codes (first in bits 1:0).
  task automatic check_seq(input string tag, input int base, input int n, input logic [9:0] seq);
    check_eq({tag, "_count"}, popped.size() - base, n);
    for (int i = 0; i < n && base + i < popped.size(); i++) begin
      check_eq(tag, 32'(popped[base+i]), 32'(seq[2*i +: 2]));
    end
  endtask

  task automatic wait_lt_start(input string tag);
    for (int i = 0; i < 400 && !lt_start; i++) tick();
    if (!lt_start) check_eq({tag, "_lt_start_timeout"}, 0, 1);
  endtask

  task automatic irq_pulse();
    hpd_irq = 1'b1;
    tick();
    hpd_irq = 1'b0;
    ticks(2);
  endtask

  int base;
  int lt_base;
  int lat;
  logic found;

  initial begin
    ticks(2);
    check_eq("rst_outputs", 32'({lt_start, link_up, evt_valid, evt_code, evt_overflow}), 0);
    rst_n = 1'b1;
    tick();

    // Clean plug with an ignored IRQ during training.
    hpd_detect = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      lat++;
      if (evt_valid) found = 1'b1;
    end
    check_eq("plug_latency", lat, 201);
    check_eq("plug_code", 32'(evt_code), 32'(EvtPlug));
    check_eq("plug_lt_start", 32'(lt_start), 1);
    tick();
    check_eq("lt_start_pulse", 32'(lt_start), 0);
    hpd_irq = 1'b1;
    tick();
    hpd_irq = 1'b0;
    ticks(2);
    lt_done = 1'b1;
    tick();
    lt_done = 1'b0;
    check_eq("link_up", 32'(link_up), 1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check_eq("train_irq_ignored", 32'(evt_valid), 0);

    // IRQs in UP, then unplug.
    base = popped.size();
    evt_ready = 1'b1;
    repeat (3) irq_pulse();
    ticks(2);
    check_seq("irq_up", base, 3, 10'b00_00_10_10_10);
    base = popped.size();
    hpd_detect = 1'b0;
    tick();
    check_eq("unplug_link_up", 32'(link_up), 0);
    ticks(2);
    check_seq("unplug", base, 1, 10'b00_00_00_00_01);

    // Glitch during settle.
    base = popped.size();
    lt_base = n_lt_start;
    hpd_detect = 1'b1;
    ticks(150);
    hpd_detect = 1'b0;
    ticks(100);
    check_eq("glitch_lt_start", n_lt_start - lt_base, 0);
    check_seq("glitch", base, 0, 10'd0);
    check_eq("glitch_state", 32'(dut.state), 32'(StDisc));

    // Retry exhaustion.
    base = popped.size();
    lt_base = n_lt_start;
    hpd_detect = 1'b1;
    for (int a = 0; a < 3; a++) begin
      wait_lt_start("retry");
      ticks(2);
      lt_fail = 1'b1;
      tick();
      lt_fail = 1'b0;
      check_eq("retry_restart", 32'(lt_start), (a < 2) ? 1 : 0);
    end
    ticks(20);
    check_eq("retry_pulses", n_lt_start - lt_base, 3);
    check_eq("retry_link_up", 32'(link_up), 0);
    check_eq("retry_state", 32'(dut.state), 32'(StFailed));
    check_seq("retry_evts", base, 2, 10'b00_00_00_11_00);
    base = popped.size();
    hpd_detect = 1'b0;
    ticks(3);
    check_seq("retry_unplug", base, 1, 10'b00_00_00_00_01);

    // Overflow with the queue stalled in UP.
    evt_ready = 1'b0;
    hpd_detect = 1'b1;
    wait_lt_start("ovf");
    ticks(2);
    lt_done = 1'b1;
    tick();
    lt_done = 1'b0;
    repeat (5) irq_pulse();
    check_eq("ovf_set", 32'(evt_overflow), 1);
    base = popped.size();
    evt_ready = 1'b1;
    hpd_irq = 1'b1;
    tick();
    evt_ready = 1'b0;
    hpd_irq = 1'b0;
    tick();
    check_eq("ovf_full_push_pop", 32'({evt_valid, evt_code}), 32'({1'b1, EvtIrq}));
    evt_ready = 1'b1;
    ticks(8);
    evt_ready = 1'b0;
    check_seq("ovf_pop", base, 5, 10'b10_10_10_10_00);
    check_eq("ovf_sticky", 32'(evt_overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(evt_overflow), 0);
    evt_ready = 1'b1;
    hpd_detect = 1'b0;
    ticks(3);

    // Unplug coinciding with lt_done.
    base = popped.size();
    hpd_detect = 1'b1;
    wait_lt_start("coll");
    ticks(2);
    hpd_detect = 1'b0;
    lt_done = 1'b1;
    tick();
    lt_done = 1'b0;
    ticks(3);
    check_eq("coll_link_up", 32'(link_up), 0);
    check_eq("coll_state", 32'(dut.state), 32'(StDisc));
    check_seq("coll_evts", base, 2, 10'b00_00_00_01_00);

    // Reset mid-training with PLUG still queued.
    evt_ready = 1'b0;
    hpd_detect = 1'b1;
    wait_lt_start("rst");
    ticks(2);
    check_eq("pre_rst_valid", 32'(evt_valid), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outputs",
             32'({lt_start, link_up, evt_valid, evt_code, evt_overflow}), 0);
    check_eq("rst_mid_state", 32'(dut.state), 32'(StDisc));
    hpd_detect = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(2);
    check_eq("post_rst_valid", 32'(evt_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
